// File: rtl/pulse_mon_pkg.sv
// rtl/pulse_mon_pkg.sv - shared types, defaults and helpers for the pulse interval monitor
package pulse_mon_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ARMED   = 2'd1,
      MEASURE = 2'd2
   } state_t;

   localparam int DEF_CNT_W      = 16;
   localparam int DEF_TIMEOUT    = 1000;
   localparam int DEF_FIFO_DEPTH = 4;
   localparam int DEF_TOT_W      = 32;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with push/pop, full/empty and drop strobe
module sync_fifo
   import pulse_mon_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   output logic             full,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             empty,
   output logic             drop
);

   localparam int AW = clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [CW-1:0]    count;
   logic             do_push;
   logic             do_pop;

   assign full  = (count == CW'(DEPTH));
   assign empty = (count == '0);
   assign do_pop  = pop & ~empty;
   // A pop in the same cycle frees the slot, so a full FIFO can still accept.
   assign do_push = push & (~full | do_pop);
   assign drop    = push & full & ~do_pop;
   assign dout    = empty ? '0 : mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/pulse_interval_monitor.sv
// rtl/pulse_interval_monitor.sv - edge detect, interval FSM, edge counter and measurement FIFO
module pulse_interval_monitor
   import pulse_mon_pkg::*;
#(
   parameter int CNT_W      = DEF_CNT_W,
   parameter int TIMEOUT    = DEF_TIMEOUT,
   parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
   parameter int TOT_W      = DEF_TOT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             pulse_in,
   input  logic             enable,
   input  logic             clear_ovf,
   output logic             m_valid,
   input  logic             m_ready,
   output logic [CNT_W-1:0] m_data,
   output logic             timeout,
   output logic             overflow,
   output logic [TOT_W-1:0] edge_total
);

   state_t           state;
   logic             pulse_d;
   logic             edge_det;
   logic [CNT_W-1:0] cnt;
   logic             push;
   logic             fifo_empty;
   logic             drop;
   logic             full_unused;

   assign edge_det = pulse_in & ~pulse_d;
   assign push     = enable & (state == MEASURE) & edge_det;
   assign m_valid  = ~fifo_empty;

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         pulse_d    <= 1'b0;
         cnt        <= '0;
         timeout    <= 1'b0;
         overflow   <= 1'b0;
         edge_total <= '0;
      end else begin
         pulse_d <= pulse_in;
         timeout <= 1'b0;
         if (state != IDLE && edge_det) edge_total <= edge_total + 1'b1;
         if (drop)           overflow <= 1'b1;
         else if (clear_ovf) overflow <= 1'b0;
         // Dropping enable abandons any interval in progress.
         if (!enable) begin
            state <= IDLE;
            cnt   <= '0;
         end else begin
            case (state)
               IDLE: state <= ARMED;
               ARMED: begin
                  if (edge_det) begin
                     cnt   <= CNT_W'(1);
                     state <= MEASURE;
                  end
               end
               MEASURE: begin
                  if (edge_det) begin
                     cnt <= CNT_W'(1);
                  end else if (cnt == CNT_W'(TIMEOUT)) begin
                     timeout <= 1'b1;
                     cnt     <= '0;
                     state   <= ARMED;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

   sync_fifo #(
      .WIDTH (CNT_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .din   (cnt),
      .full  (full_unused),
      .pop   (m_ready),
      .dout  (m_data),
      .empty (fifo_empty),
      .drop  (drop)
   );

endmodule

// File: tb/tb_pulse_interval_monitor.sv
// tb/tb_pulse_interval_monitor.sv - scoreboard bench with timestamp-based reference model
module tb_pulse_interval_monitor;

   localparam int CNT_W   = 16;
   localparam int TMO     = 1000;
   localparam int DEPTH   = 4;
   localparam int TOT_W   = 32;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             pulse_in = 1'b0;
   logic             enable = 1'b0;
   logic             clear_ovf = 1'b0;
   logic             m_valid;
   logic             m_ready = 1'b0;
   logic [CNT_W-1:0] m_data;
   logic             timeout;
   logic             overflow;
   logic [TOT_W-1:0] edge_total;

   pulse_interval_monitor #(
      .CNT_W      (CNT_W),
      .TIMEOUT    (TMO),
      .FIFO_DEPTH (DEPTH),
      .TOT_W      (TOT_W)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .pulse_in   (pulse_in),
      .enable     (enable),
      .clear_ovf  (clear_ovf),
      .m_valid    (m_valid),
      .m_ready    (m_ready),
      .m_data     (m_data),
      .timeout    (timeout),
      .overflow   (overflow),
      .edge_total (edge_total)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   bit checking = 0;

   // reference model: timestamps of edges rather than a running counter
   int unsigned sb[$];
   int unsigned seen[$];
   longint      cyc = 0;
   longint      t0 = 0;
   bit          have_t0 = 0;
   bit          on = 0;
   bit          prev = 0;
   int unsigned exp_total = 0;
   bit          exp_ovf = 0;
   bit          exp_to = 0;
   int          n_to = 0;
   bit          en_v = 0;
   bit          rdy_v = 0;

   task automatic chk(input string name, input longint act, input longint exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic step(input bit p, input bit clr, input bit r);
      int  occ;
      bit  pop, e, meas_v, to_n;
      longint meas;
      pulse_in  = p;
      clear_ovf = clr;
      rst       = r;
      enable    = en_v;
      m_ready   = rdy_v;
      occ = sb.size();
      @(posedge clk);
      #1;
      meas_v = 0;
      to_n   = 0;
      meas   = 0;
      if (r) begin
         sb.delete();
         exp_total = 0;
         exp_ovf   = 0;
         on        = 0;
         have_t0   = 0;
         prev      = 0;
      end else begin
         e   = p && !prev;
         pop = (occ > 0) && rdy_v;
         if (!on) begin
            if (en_v) on = 1;
            have_t0 = 0;
         end else if (!en_v) begin
            if (e) exp_total++;
            on      = 0;
            have_t0 = 0;
         end else if (e) begin
            exp_total++;
            if (have_t0) begin
               meas   = cyc - t0;
               meas_v = 1;
            end
            t0      = cyc;
            have_t0 = 1;
         end else if (have_t0 && (cyc - t0 == TMO)) begin
            to_n    = 1;
            have_t0 = 0;
         end
         prev = p;
         if (meas_v) begin
            if (occ == DEPTH && !pop) exp_ovf = 1;
            else sb.push_back(int'(meas));
         end
         if (!(meas_v && occ == DEPTH && !pop) && clr) exp_ovf = 0;
      end
      exp_to = to_n;
      cyc++;
   endtask

   task automatic pulse_gap(input int gap);
      step(1, 0, 0);
      for (int i = 1; i < gap; i++) step(0, 0, 0);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0);
   endtask

   task automatic do_reset();
      step(0, 0, 1);
      step(0, 0, 1);
   endtask

   always @(negedge clk) begin
      if (checking) begin
         int unsigned exp_d;
         chk("m_valid", m_valid, sb.size() != 0);
         if (!rst && m_valid && m_ready) begin
            if (sb.size() == 0) begin
               chk("pop_unexpected", 1, 0);
            end else begin
               exp_d = sb.pop_front();
               chk("m_data", m_data, exp_d);
               seen.push_back(m_data);
            end
         end
         chk("timeout", timeout, exp_to);
         chk("overflow", overflow, exp_ovf);
         chk("edge_total", edge_total, exp_total);
         if (timeout) n_to++;
      end
   end

   initial begin
      int base, w, gap;
      do_reset();
      checking = 1;
      chk("rst_m_valid", m_valid, 0);
      chk("rst_m_data", m_data, 0);
      chk("rst_timeout", timeout, 0);
      chk("rst_overflow", overflow, 0);
      chk("rst_edge_total", edge_total, 0);

      // regular 10-cycle pulses
      en_v = 1; rdy_v = 1;
      idle(2);
      base = seen.size();
      for (int i = 0; i < 5; i++) pulse_gap(10);
      chk("t1_outputs", seen.size() - base, 4);
      chk("t1_value", seen[seen.size()-1], 10);
      chk("t1_edges", edge_total, 5);

      // gap equal to and beyond the timeout
      base = seen.size();
      pulse_gap(1000);
      pulse_gap(1001);
      pulse_gap(7);
      pulse_gap(3);
      chk("t2_outputs", seen.size() - base, 3);
      chk("t2_exact", seen[base+1], 1000);
      chk("t2_fresh", seen[base+2], 7);
      chk("t2_timeouts", n_to, 1);

      // overflow with consumer stalled
      do_reset();
      rdy_v = 0;
      idle(1);
      for (int i = 0; i < 7; i++) pulse_gap(5);
      chk("t3_overflow", overflow, 1);
      chk("t3_stored", m_valid, 1);
      base = seen.size();
      rdy_v = 1;
      idle(6);
      chk("t3_drained", seen.size() - base, 4);
      step(0, 1, 0);
      chk("t3_cleared", overflow, 0);

      // push into full FIFO while popping
      do_reset();
      rdy_v = 0;
      idle(1);
      for (int i = 0; i < 5; i++) pulse_gap(4);
      base = seen.size();
      rdy_v = 1;
      step(1, 0, 0);
      rdy_v = 0;
      idle(3);
      rdy_v = 1;
      idle(6);
      chk("t4_no_ovf", overflow, 0);
      chk("t4_outputs", seen.size() - base, 5);

      // enable dropped mid-interval
      do_reset();
      rdy_v = 1;
      idle(1);
      base = seen.size();
      for (int i = 0; i < 3; i++) pulse_gap(6);
      step(1, 0, 0);
      idle(2);
      en_v = 0;
      idle(3);
      en_v = 1;
      idle(2);
      pulse_gap(6);
      pulse_gap(6);
      chk("t5_outputs", seen.size() - base, 4);
      chk("t5_edges", edge_total, 6);

      // reset with FIFO half full, mid-measurement
      rdy_v = 0;
      for (int i = 0; i < 3; i++) pulse_gap(5);
      step(0, 0, 1);
      chk("t6_m_valid", m_valid, 0);
      chk("t6_edge_total", edge_total, 0);
      chk("t6_overflow", overflow, 0);

      // randomized traffic
      for (int s = 0; s < 150; s++) begin
         gap = ($urandom_range(0, 19) == 0) ? int'($urandom_range(995, 1005))
                                            : int'($urandom_range(2, 30));
         w = (gap > 2 && $urandom_range(0, 1) == 1) ? 2 : 1;
         en_v = ($urandom_range(0, 7) != 0);
         for (int i = 0; i < gap; i++) begin
            rdy_v = ($urandom_range(0, 2) != 0);
            step(i < w, $urandom_range(0, 15) == 0, $urandom_range(0, 499) == 0);
         end
      end
      rdy_v = 1;
      idle(6);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
